ex_stage: RTL

Execute stage of the five-stage pipeline, between the ID/EX register and the memory stage. Computes the ALU result for the instruction in EX, runs unsigned multiply/divide iteratively into HI/LO, and raises a stall to the hazard logic when an instruction depends on an unfinished multiply/divide. Owns the EX/MEM pipeline register that drives the memory stage's write-enable, address/store-data and writeback-control inputs.

---
 rtl/ex_pkg.sv | 41 ++++
 rtl/dff.sv | 43 ++++
 rtl/ex_muldiv.sv | 108 ++++++++++
 rtl/ex_stage.sv | 96 +++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// ex_pkg -- shared definitions for the execute stage.
//   alu_op_t   : 4-bit operation codes driven on ex_aluc
//   md_state_t : multiply/divide sequencer states
//   MD_CYCLES  : iterations of one unsigned multiply or divide
//   isMdOp / isMdDependent : classify codes that start or need the muldiv unit
package ex_pkg;

  localparam int MD_CYCLES = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_LUI   = 4'd5,
    ALU_SLL   = 4'd6,
    ALU_SRL   = 4'd7,
    ALU_SRA   = 4'd8,
    ALU_SLT   = 4'd9,
    ALU_MULTU = 4'd10,
    ALU_DIVU  = 4'd11,
    ALU_MFHI  = 4'd12,
    ALU_MFLO  = 4'd13
  } alu_op_t;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  function automatic logic isMdOp(input logic [3:0] aluc);
    return (aluc == ALU_MULTU) || (aluc == ALU_DIVU);
  endfunction

  // Anything that starts the unit or reads HI/LO must wait while it is busy.
  function automatic logic isMdDependent(input logic [3:0] aluc);
    return isMdOp(aluc) || (aluc == ALU_MFHI) || (aluc == ALU_MFLO);
  endfunction

endpackage

// File: rtl/dff.sv
// Codebase flops: positive-edge registers with asynchronous active-low clear.
//   clk  : clock
//   clrn : asynchronous clear, active low
//   d    : next value
//   q    : registered value
module dff1 (
  input  logic clk,
  input  logic clrn,
  input  logic d,
  output logic q
);
  // Single-bit register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) q <= 1'b0;
    else       q <= d;
  end
endmodule

module dff5 (
  input  logic       clk,
  input  logic       clrn,
  input  logic [4:0] d,
  output logic [4:0] q
);
  // Register-number sized register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) q <= '0;
    else       q <= d;
  end
endmodule

module dff32 (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] d,
  output logic [31:0] q
);
  // Word sized register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) q <= '0;
    else       q <= d;
  end
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv -- iterative unsigned multiply (shift-add) and divide (restoring)
// that writes HI/LO after ITERS single-bit steps. Only built when EX_MULDIV_EN
// is defined.
//   clk, clrn : clock, asynchronous active-low clear (drops any operation)
//   i_start   : accept a new operation (honoured only while idle)
//   i_op      : 0 = multiply, 1 = divide
//   i_a, i_b  : operands (dividend/divisor for divide)
//   o_busy    : an operation is in progress
//   o_hi/o_lo : product high/low, or remainder/quotient
module ex_muldiv
  import ex_pkg::*;
#(
  parameter int ITERS = MD_CYCLES
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        i_start,
  input  logic        i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_busy,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  localparam int CNT_W = $clog2(ITERS);

  md_state_t        r_state, w_nextState;
  logic [CNT_W-1:0] r_cnt;
  logic             r_isDiv;
  logic [31:0]      r_opnd, r_accHi, r_accLo, r_hi, r_lo;
  logic [32:0]      w_sum, w_shift;
  logic [31:0]      w_diff, w_nxtHi, w_nxtLo;
  logic             w_fits, w_last;

  assign w_last = (r_cnt == CNT_W'(ITERS - 1));

  // State register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) r_state <= MD_IDLE;
    else       r_state <= w_nextState;
  end

  // Next state: leave IDLE on a start, return after the final iteration.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      MD_IDLE: if (i_start) w_nextState = MD_BUSY;
      MD_BUSY: if (w_last)  w_nextState = MD_IDLE;
      default: w_nextState = MD_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    o_busy = (r_state == MD_BUSY);
    o_hi   = r_hi;
    o_lo   = r_lo;
  end

  // One iteration. Multiply keeps {acc_hi, acc_lo} as partial product and the
  // remaining multiplier bits, shifting right. Divide keeps remainder in
  // acc_hi and shifts dividend bits out of acc_lo while quotient bits shift in.
  // A zero divisor always "fits", which yields all-ones quotient and HI = A.
  always_comb begin
    w_sum   = {1'b0, r_accHi} + (r_accLo[0] ? {1'b0, r_opnd} : 33'd0);
    w_shift = {r_accHi, r_accLo[31]};
    w_fits  = (w_shift >= {1'b0, r_opnd});
    w_diff  = w_shift[31:0] - r_opnd;
    if (r_isDiv) begin
      w_nxtHi = w_fits ? w_diff : w_shift[31:0];
      w_nxtLo = {r_accLo[30:0], w_fits};
    end else begin
      w_nxtHi = w_sum[32:1];
      w_nxtLo = {w_sum[0], r_accLo[31:1]};
    end
  end

  // Operand latch on start, iteration while busy, HI/LO write on the last step.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_cnt   <= '0;
      r_isDiv <= 1'b0;
      r_opnd  <= '0;
      r_accHi <= '0;
      r_accLo <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (r_state == MD_IDLE) begin
      if (i_start) begin
        r_cnt   <= '0;
        r_isDiv <= i_op;
        r_accHi <= '0;
        r_opnd  <= i_op ? i_b : i_a;
        r_accLo <= i_op ? i_a : i_b;
      end
    end else begin
      r_accHi <= w_nxtHi;
      r_accLo <= w_nxtLo;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_hi <= w_nxtHi;
        r_lo <= w_nxtLo;
      end
    end
  end

endmodule

// File: rtl/ex_stage.sv
// ex_stage -- execute stage: ALU, optional multiply/divide unit with HI/LO,
// dependency stall, and the EX/MEM pipeline register.
// Define EX_MULDIV_EN to build the muldiv unit; without it MULTU/DIVU/MFHI/MFLO
// yield 0 and ex_stall is constant 0.
//   clk, clrn          : clock, asynchronous active-low reset
//   ex_a, ex_b, ex_imm : operands (ex_imm[10:6] is the shift amount, ex_b is store data)
//   ex_aluc            : operation code (alu_op_t)
//   ex_aluimm/ex_shift : operand B / operand A selects
//   ex_wreg/m2reg/wmem, ex_d : control and destination from ID
//   ex_stall           : hold earlier stages this cycle
//   mem_*              : registered outputs to the memory stage
module ex_stage
  import ex_pkg::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] ex_a,
  input  logic [31:0] ex_b,
  input  logic [31:0] ex_imm,
  input  logic [3:0]  ex_aluc,
  input  logic        ex_aluimm,
  input  logic        ex_shift,
  input  logic        ex_wreg,
  input  logic        ex_m2reg,
  input  logic        ex_wmem,
  input  logic [4:0]  ex_d,
  output logic        ex_stall,
  output logic        mem_wreg,
  output logic        mem_m2reg,
  output logic        mem_wmem,
  output logic [4:0]  mem_d,
  output logic [31:0] mem_alu,
  output logic [31:0] mem_b
);

  logic [31:0] w_opA, w_opB, w_result, w_hi, w_lo;

  assign w_opA = ex_shift  ? {27'b0, ex_imm[10:6]} : ex_a;
  assign w_opB = ex_aluimm ? ex_imm : ex_b;

`ifdef EX_MULDIV_EN
  logic w_busy;

  ex_muldiv #(.ITERS(MD_CYCLES)) u_muldiv (
    .clk     (clk),
    .clrn    (clrn),
    .i_start (isMdOp(ex_aluc) && !ex_stall),
    .i_op    (ex_aluc == ALU_DIVU),
    .i_a     (w_opA),
    .i_b     (w_opB),
    .o_busy  (w_busy),
    .o_hi    (w_hi),
    .o_lo    (w_lo)
  );

  assign ex_stall = w_busy && isMdDependent(ex_aluc);
`else
  logic [31:0] w_unused;

  assign w_unused = 32'(MD_CYCLES);
  assign w_hi     = '0;
  assign w_lo     = '0;
  assign ex_stall = 1'b0;
`endif

  // ALU. MULTU/DIVU deliver 0 to the pipeline; their results live in HI/LO.
  always_comb begin
    w_result = '0;
    case (ex_aluc)
      ALU_ADD:  w_result = w_opA + w_opB;
      ALU_SUB:  w_result = w_opA - w_opB;
      ALU_AND:  w_result = w_opA & w_opB;
      ALU_OR:   w_result = w_opA | w_opB;
      ALU_XOR:  w_result = w_opA ^ w_opB;
      ALU_LUI:  w_result = {w_opB[15:0], 16'h0};
      ALU_SLL:  w_result = w_opB << w_opA[4:0];
      ALU_SRL:  w_result = w_opB >> w_opA[4:0];
      ALU_SRA:  w_result = $signed(w_opB) >>> w_opA[4:0];
      ALU_SLT:  w_result = {31'b0, $signed(w_opA) < $signed(w_opB)};
      ALU_MFHI: w_result = w_hi;
      ALU_MFLO: w_result = w_lo;
      default:  w_result = '0;
    endcase
  end

  // EX/MEM register: a stalled instruction stays in EX, so a bubble goes on.
  dff1  u_memWreg  (.clk(clk), .clrn(clrn), .d(ex_stall ? 1'b0  : ex_wreg),  .q(mem_wreg));
  dff1  u_memM2reg (.clk(clk), .clrn(clrn), .d(ex_stall ? 1'b0  : ex_m2reg), .q(mem_m2reg));
  dff1  u_memWmem  (.clk(clk), .clrn(clrn), .d(ex_stall ? 1'b0  : ex_wmem),  .q(mem_wmem));
  dff5  u_memD     (.clk(clk), .clrn(clrn), .d(ex_stall ? 5'd0  : ex_d),     .q(mem_d));
  dff32 u_memAlu   (.clk(clk), .clrn(clrn), .d(ex_stall ? 32'd0 : w_result), .q(mem_alu));
  dff32 u_memB     (.clk(clk), .clrn(clrn), .d(ex_stall ? 32'd0 : ex_b),     .q(mem_b));

endmodule
